// File: rtl/chdel_pkg.sv
// Shared types and defaults for the channel delay array.
package chdel_pkg;

    localparam int unsigned CHDEL_NCH_DEFAULT = 4;
    localparam int unsigned CHDEL_DW_DEFAULT  = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DELAY = 2'd1,
        PULSE = 2'd2
    } chdel_state_e;

endpackage

// File: rtl/ch_delay_array_if.sv
// Signal bundles: one per delay channel, and the full array view used by the bench.
interface chdel_ch_if
    import chdel_pkg::*;
#(
    parameter int unsigned DW = CHDEL_DW_DEFAULT
);
    logic          ch_en;
    logic          start;
    logic          mode;
    logic [DW-1:0] delay;
    logic [DW-1:0] width;
    logic          ext_done;
    logic          abort;
    logic          out;
    logic          busy;
    logic          done;

    modport master (
        output ch_en, start, mode, delay, width, ext_done, abort,
        input  out, busy, done
    );

    modport slave (
        input  ch_en, start, mode, delay, width, ext_done, abort,
        output out, busy, done
    );
endinterface

interface ch_delay_array_if
    import chdel_pkg::*;
#(
    parameter int unsigned NCH = CHDEL_NCH_DEFAULT,
    parameter int unsigned DW  = CHDEL_DW_DEFAULT
);
    logic [NCH-1:0]    ch_en;
    logic [NCH-1:0]    start;
    logic              mode;
    logic [NCH*DW-1:0] delay;
    logic [NCH*DW-1:0] width;
    logic [NCH-1:0]    ext_done;
    logic              abort;
    logic [NCH-1:0]    out;
    logic [NCH-1:0]    busy;
    logic [NCH-1:0]    done;

    modport master (
        output ch_en, start, mode, delay, width, ext_done, abort,
        input  out, busy, done
    );

    modport slave (
        input  ch_en, start, mode, delay, width, ext_done, abort,
        output out, busy, done
    );
endinterface

// File: rtl/chdel_channel.sv
// One delay channel: IDLE -> DELAY -> PULSE -> IDLE, pulse ended by width count or analog return.
// CHDEL_GZI_SYNC_EN: pass ext_done through a 2-flop synchroniser before use.
module chdel_channel
    import chdel_pkg::*;
#(
    parameter int unsigned DW = CHDEL_DW_DEFAULT
) (
    input logic       i_clk,
    input logic       i_rst_n,
    chdel_ch_if.slave ch
);

    localparam logic [DW-1:0] ONE = DW'(1);

    chdel_state_e  state, state_nx;
    logic [DW-1:0] cnt, cnt_nx;
    logic [DW-1:0] width_q, width_nx;
    logic          mode_q, mode_nx;
    logic          done_nx;
    logic          start_d;
    logic          primed;
    logic          out_q, busy_q, done_q;
    logic          ext_s;
    logic          start_edge;

`ifdef CHDEL_GZI_SYNC_EN
    logic [1:0] ext_sync;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) ext_sync <= '0;
        else          ext_sync <= {ext_sync[0], ch.ext_done};
    end

    assign ext_s = ext_sync[1];
`else
    assign ext_s = ch.ext_done;
`endif

    // primed blocks the first cycle after reset so a held-high start is not an edge
    assign start_edge = primed & ch.start & ~start_d;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        width_nx = width_q;
        mode_nx  = mode_q;
        done_nx  = 1'b0;
        if (ch.abort || !ch.ch_en) begin
            state_nx = IDLE;
            cnt_nx   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_edge) begin
                        mode_nx  = ch.mode;
                        width_nx = ch.width;
                        // a zero delay skips DELAY so the pulse still rises one cycle after the edge
                        if (ch.delay == '0) begin
                            state_nx = PULSE;
                            cnt_nx   = ch.width;
                        end else begin
                            state_nx = DELAY;
                            cnt_nx   = ch.delay;
                        end
                    end
                end
                DELAY: begin
                    if (cnt <= ONE) begin
                        state_nx = PULSE;
                        cnt_nx   = width_q;
                    end else begin
                        cnt_nx = cnt - ONE;
                    end
                end
                PULSE: begin
                    if (mode_q) begin
                        if (cnt <= ONE) begin
                            state_nx = IDLE;
                            cnt_nx   = '0;
                            done_nx  = 1'b1;
                        end else begin
                            cnt_nx = cnt - ONE;
                        end
                    end else if (ext_s) begin
                        state_nx = IDLE;
                        done_nx  = 1'b1;
                    end
                end
                default: begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            width_q <= '0;
            mode_q  <= 1'b0;
            start_d <= 1'b0;
            primed  <= 1'b0;
            out_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            width_q <= width_nx;
            mode_q  <= mode_nx;
            start_d <= ch.start;
            primed  <= 1'b1;
            out_q   <= (state_nx == PULSE);
            busy_q  <= (state_nx != IDLE);
            done_q  <= done_nx;
        end
    end

    assign ch.out  = out_q;
    assign ch.busy = busy_q;
    assign ch.done = done_q;

endmodule

// File: rtl/ch_delay_array.sv
// Array of NCH independent programmable delay/pulse channels.
// CHDEL_GZI_SYNC_EN selects a 2-flop synchroniser on i_ext_done inside each channel.
module ch_delay_array
    import chdel_pkg::*;
#(
    parameter int unsigned NCH = CHDEL_NCH_DEFAULT,
    parameter int unsigned DW  = CHDEL_DW_DEFAULT
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [NCH-1:0]    i_ch_en,
    input  logic [NCH-1:0]    i_start,
    input  logic              i_mode,
    input  logic [NCH*DW-1:0] i_delay,
    input  logic [NCH*DW-1:0] i_width,
    input  logic [NCH-1:0]    i_ext_done,
    input  logic              i_abort,
    output logic [NCH-1:0]    o_out,
    output logic [NCH-1:0]    o_busy,
    output logic [NCH-1:0]    o_done
);

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        chdel_ch_if #(.DW(DW)) ch_bus ();

        assign ch_bus.ch_en    = i_ch_en[k];
        assign ch_bus.start    = i_start[k];
        assign ch_bus.mode     = i_mode;
        assign ch_bus.delay    = i_delay[k*DW +: DW];
        assign ch_bus.width    = i_width[k*DW +: DW];
        assign ch_bus.ext_done = i_ext_done[k];
        assign ch_bus.abort    = i_abort;

        chdel_channel #(.DW(DW)) u_ch (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .ch      (ch_bus)
        );

        assign o_out[k]  = ch_bus.out;
        assign o_busy[k] = ch_bus.busy;
        assign o_done[k] = ch_bus.done;
    end

endmodule

// File: doc/ch_delay_array.md
CH_DELAY_ARRAY -- requirements
Module: ch_delay_array

Interface
REQ-001 SHALL have parameter NCH, default 4, number of independent delay channels (1..16).
REQ-002 SHALL have parameter DW, default 16, delay/width counter bit width (4..32).
REQ-003 SHALL have port i_clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port i_rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port i_ch_en  input  NCH  per-channel enable.
REQ-006 SHALL have port i_start  input  NCH  per-channel start, synchronous, rising-edge detected.
REQ-007 SHALL have port i_mode  input  1  0 = GZI (pulse ends on analog return), 1 = GVI (pulse ends on width count).
REQ-008 SHALL have port i_delay  input  NCH*DW  per-channel delay, channel k at [k*DW +: DW].
REQ-009 SHALL have port i_width  input  NCH*DW  per-channel GVI pulse width, same packing.
REQ-010 SHALL have port i_ext_done  input  NCH  asynchronous analog-return level, active-high.
REQ-011 SHALL have port i_abort  input  1  global synchronous abort.
REQ-012 SHALL have port o_out  output  NCH  registered delayed output pulse.
REQ-013 SHALL have port o_busy  output  NCH  channel in DELAY or PULSE.
REQ-014 SHALL have port o_done  output  NCH  one-cycle strobe on PULSE end.

Function
REQ-015 Each channel SHALL run an FSM IDLE -> DELAY -> PULSE -> IDLE.
REQ-016 IDLE->DELAY when i_ch_en[k]=1 and i_start[k] rising edge (high now, low previous cycle); i_delay[k] and i_width[k] captured that cycle.
REQ-017 DELAY SHALL down-count the captured delay D; o_out[k] SHALL rise exactly D+1 cycles after the start-edge cycle (D=0 -> 1 cycle).
REQ-018 GVI: PULSE SHALL last max(W,1) cycles, W = captured width, then IDLE.
REQ-019 GZI: PULSE SHALL end the cycle after synchronised i_ext_done[k] is high; if high on PULSE entry, pulse lasts 1 cycle.
REQ-020 i_mode SHALL be sampled at the start edge; later changes have no effect on a running channel.
REQ-021 o_done[k] SHALL pulse one cycle coincident with the first cycle o_out[k] is low after PULSE.
REQ-022 Start edges while busy SHALL be ignored; i_delay/i_width changes while busy SHALL be ignored.
REQ-023 i_ch_en[k] falling or i_abort=1 SHALL force the channel to IDLE next cycle, o_out low, no o_done.
REQ-024 Start edge and i_abort in the same cycle: abort wins.
REQ-025 D = 2^DW-1 SHALL count fully without wrap; counters never wrap below zero.
REQ-026 Channels SHALL be fully independent; simultaneous starts on all channels SHALL all run.

Reset
REQ-027 On i_rst_n=0 all FSMs SHALL go IDLE, counters 0, edge-detect history 0, o_out/o_busy/o_done = 0, asynchronously.
REQ-028 Reset release SHALL NOT create a start edge even if i_start is high.

Configuration
REQ-029 Macro CHDEL_GZI_SYNC_EN defined: i_ext_done passes a 2-flop synchroniser (GZI end latency = 2 cycles after input rise + 1).
REQ-030 Macro undefined: i_ext_done used directly (input is already synchronous), GZI end latency = 1 cycle.

Structure
REQ-031 Package chdel_pkg SHALL hold the FSM state enum (IDLE, DELAY, PULSE) and DW default constant.
REQ-032 Per-channel logic SHALL be sub-module chdel_channel, instantiated NCH times by generate.

Verification
REQ-033 D=5, GVI, W=3, start ch0 -> o_out[0] high cycles 6..8, o_done[0] cycle 9.
REQ-034 D=0, GVI, W=0 -> o_out high exactly 1 cycle at cycle 1.
REQ-035 GZI, D=2, ext_done rises 10 cycles later -> pulse ends per REQ-029/030 latency, o_done once.
REQ-036 Restart edge mid-DELAY, then i_abort mid-PULSE -> restart ignored, o_out low next cycle, no o_done.
REQ-037 All NCH channels started same cycle, distinct D -> each o_out independently correct; i_rst_n low mid-run clears all outputs immediately.
